// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a range of layer-table entries, issuing one
// start pulse per layer and tracking OFM base addresses.
module layer_sequencer #(
  parameter  int NUM_LAYER    = 13,
  parameter  int OFM_RAM_SIZE = 2378675,
  localparam int LW    = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1,
  localparam int AW    = $clog2(OFM_RAM_SIZE),
  localparam int CFG_W = 37 + (LW + 1) + AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_CNN,
  input  logic [LW-1:0]    first_layer,
  input  logic [LW-1:0]    last_layer,
  input  logic             abort,
  input  logic             cfg_we,
  input  logic [LW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  input  logic             done_layer,
  output logic             start_layer,
  output logic             done_CNN,
  output logic             aborted,
  output logic             busy,
  output logic [LW-1:0]    count_layer,
  output logic [8:0]       ifm_size,
  output logic [10:0]      ifm_channel,
  output logic [1:0]       kernel_size,
  output logic [10:0]      num_filter,
  output logic             maxpool_mode,
  output logic [1:0]       maxpool_stride,
  output logic             upsample_mode,
  output logic [AW-1:0]    start_write_addr,
  output logic [AW-1:0]    start_read_addr
);

  typedef struct packed {
    logic [8:0]    isz;
    logic [10:0]   ich;
    logic [1:0]    ks;
    logic [10:0]   nf;
    logic          mpm;
    logic [1:0]    mps;
    logic          up;
    logic [LW:0]   src;
    logic [AW-1:0] ofm;
  } ent_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, NEXT, FIN
  } state_t;

  localparam logic [LW:0] NL     = (LW+1)'(NUM_LAYER);
  localparam logic [AW:0] RAM_SZ = (AW+1)'(OFM_RAM_SIZE);

  state_t        state_q;
  ent_t          tbl_q [NUM_LAYER];
  ent_t          ent_q;
  ent_t          cur_q;
  logic [AW-1:0] hist_q [NUM_LAYER];
  logic [LW-1:0] first_q, last_q, cnt_q;
  logic [AW-1:0] wp_q, wr_q, rd_q;
  logic          stl_q, dcnn_q, abt_q;

  logic [AW:0]   sum;
  logic [AW-1:0] wp_d;
  logic [AW-1:0] rd_d;
  logic [LW-1:0] nxt_cnt;
  logic          go;

  assign go      = start_CNN && (first_layer <= last_layer)
                   && ({1'b0, last_layer} < NL);
  assign nxt_cnt = cnt_q + LW'(1);
  assign sum     = {1'b0, wp_q} + {1'b0, cur_q.ofm};
  assign wp_d    = (sum >= RAM_SZ) ? AW'(sum - RAM_SZ)
                                   : sum[AW-1:0];

  // Read base: 0 for the run's first layer, else chained or routed
  always_comb begin
    rd_d = '0;
    if (cnt_q == first_q)
      rd_d = '0;
    else if (ent_q.src[LW])
      rd_d = wr_q;
    else if ({1'b0, ent_q.src[LW-1:0]} < NL)
      rd_d = hist_q[ent_q.src[LW-1:0]];
  end

  // Table storage survives reset; writes accepted only while idle
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == IDLE && ({1'b0, cfg_addr} < NL))
      tbl_q[cfg_addr] <= ent_t'(cfg_wdata);
  end

  // Sequencer FSM with registered pulses, fields and addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ent_q   <= '0;
      cur_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      stl_q   <= 1'b0;
      dcnn_q  <= 1'b0;
      abt_q   <= 1'b0;
      for (int i = 0; i < NUM_LAYER; i++) hist_q[i] <= '0;
    end else begin
      stl_q  <= 1'b0;
      dcnn_q <= 1'b0;
      abt_q  <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        abt_q   <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: if (go) begin
            first_q <= first_layer;
            last_q  <= last_layer;
            cnt_q   <= first_layer;
            wp_q    <= '0;
            ent_q   <= tbl_q[first_layer];
            state_q <= LOAD;
          end
          LOAD: begin
            cur_q   <= ent_q;
            wr_q    <= wp_q;
            rd_q    <= rd_d;
            stl_q   <= 1'b1;
            state_q <= START;
          end
          START: state_q <= RUN;
          RUN: if (done_layer) state_q <= NEXT;
          NEXT: begin
            hist_q[cnt_q] <= wr_q;
            wp_q          <= wp_d;
            if (cnt_q == last_q) begin
              dcnn_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              cnt_q   <= nxt_cnt;
              ent_q   <= tbl_q[nxt_cnt];
              state_q <= LOAD;
            end
          end
          FIN: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy             = (state_q != IDLE);
  assign start_layer      = stl_q;
  assign done_CNN         = dcnn_q;
  assign aborted          = abt_q;
  assign count_layer      = cnt_q;
  assign ifm_size         = cur_q.isz;
  assign ifm_channel      = cur_q.ich;
  assign kernel_size      = cur_q.ks;
  assign num_filter       = cur_q.nf;
  assign maxpool_mode     = cur_q.mpm;
  assign maxpool_stride   = cur_q.mps;
  assign upsample_mode    = cur_q.up;
  assign start_write_addr = wr_q;
  assign start_read_addr  = rd_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: directed runs with
// expected pulses queued by the driver and popped by a monitor.
module tb_layer_sequencer;
  localparam int LW = 4;
  localparam int AW = 22;
  localparam int CW = 64;

  logic clk = 0;
  logic rst_n = 0;
  logic start_CNN = 0;
  logic abort = 0;
  logic cfg_we = 0;
  logic done_layer = 0;
  logic [LW-1:0] first_layer = '0;
  logic [LW-1:0] last_layer = '0;
  logic [LW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic start_layer, done_CNN, aborted, busy;
  logic [LW-1:0] count_layer;
  logic [8:0] ifm_size;
  logic [10:0] ifm_channel, num_filter;
  logic [1:0] kernel_size, maxpool_stride;
  logic maxpool_mode, upsample_mode;
  logic [AW-1:0] start_write_addr, start_read_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    int cnt;
    int wr;
    int rd;
    int isz;
  } ev_t;
  ev_t sb[$];

  layer_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start_CNN(start_CNN),
    .first_layer(first_layer),
    .last_layer(last_layer),
    .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .done_layer(done_layer),
    .start_layer(start_layer),
    .done_CNN(done_CNN),
    .aborted(aborted), .busy(busy),
    .count_layer(count_layer),
    .ifm_size(ifm_size),
    .ifm_channel(ifm_channel),
    .kernel_size(kernel_size),
    .num_filter(num_filter),
    .maxpool_mode(maxpool_mode),
    .maxpool_stride(maxpool_stride),
    .upsample_mode(upsample_mode),
    .start_write_addr(start_write_addr),
    .start_read_addr(start_read_addr)
  );

  always #5 clk = ~clk;

  function automatic void check(string n, longint act,
                                longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  function automatic void exp_start(int c, int wr, int rd,
                                    int isz);
    ev_t e;
    e.kind = 0; e.cnt = c; e.wr = wr; e.rd = rd; e.isz = isz;
    sb.push_back(e);
  endfunction

  function automatic void exp_evt(int k);
    ev_t e;
    e.kind = k; e.cnt = 0; e.wr = 0; e.rd = 0; e.isz = 0;
    sb.push_back(e);
  endfunction

  function automatic logic [CW-1:0] pack(int isz, int ofm,
                                         int src);
    logic [8:0] s;
    logic [4:0] q;
    logic [21:0] o;
    s = isz[8:0]; q = src[4:0]; o = ofm[21:0];
    return {s, 11'd3, 2'd1, 11'd16, 1'b0, 2'd2, 1'b0, q, o};
  endfunction

  task automatic cfg_write(int a, int isz, int ofm, int src);
    @(negedge clk);
    cfg_we = 1; cfg_addr = a[LW-1:0];
    cfg_wdata = pack(isz, ofm, src);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic wait_start();
    int cyc;
    cyc = 1;
    while (!start_layer && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("start_lat", cyc, 2);
  endtask

  task automatic start_run(int f, int l);
    @(negedge clk);
    start_CNN = 1;
    first_layer = f[LW-1:0];
    last_layer = l[LW-1:0];
    @(negedge clk);
    start_CNN = 0;
    wait_start();
  endtask

  task automatic finish_layer(bit last);
    int cyc;
    repeat (5) @(negedge clk);
    done_layer = 1;
    @(negedge clk);
    done_layer = 0;
    cyc = 1;
    while (!(start_layer || done_CNN) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (last) check("done_lat", cyc, 2);
    else      check("next_lat", cyc, 3);
  endtask

  // Monitor: every output pulse must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (start_layer || done_CNN || aborted) begin
        int k;
        ev_t e;
        k = start_layer ? 0 : (done_CNN ? 1 : 2);
        if (sb.size() == 0) begin
          check("unexpected_evt", k, -1);
        end else begin
          e = sb.pop_front();
          check("evt_kind", k, e.kind);
          if (k == 0 && e.kind == 0) begin
            check("count_layer", count_layer, e.cnt);
            check("wr_addr", start_write_addr, e.wr);
            check("rd_addr", start_read_addr, e.rd);
            check("ifm_size", ifm_size, e.isz);
            check("fields",
                  {ifm_channel, kernel_size, num_filter,
                   maxpool_mode, maxpool_stride, upsample_mode},
                  {11'd3, 2'd1, 11'd16, 1'b0, 2'd2, 1'b0});
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", start_layer, 0);
    check("rst_done", done_CNN, 0);
    check("rst_abort", aborted, 0);
    check("rst_count", count_layer, 0);
    check("rst_wr", start_write_addr, 0);
    check("rst_rd", start_read_addr, 0);
    check("rst_isz", ifm_size, 0);
    rst_n = 1;

    // three chained layers
    cfg_write(0, 10, 100, 16);
    cfg_write(1, 11, 200, 16);
    cfg_write(2, 12, 50, 16);
    exp_start(0, 0, 0, 10);
    exp_start(1, 100, 0, 11);
    exp_start(2, 300, 100, 12);
    exp_evt(1);
    start_run(0, 2);
    finish_layer(0);
    finish_layer(0);
    finish_layer(1);

    // skip connection to layer 0
    cfg_write(2, 12, 50, 0);
    exp_start(0, 0, 0, 10);
    exp_start(1, 100, 0, 11);
    exp_start(2, 300, 0, 12);
    exp_evt(1);
    start_run(0, 2);
    finish_layer(0);
    finish_layer(0);
    finish_layer(1);

    // write pointer wrap
    cfg_write(3, 20, 2000000, 16);
    cfg_write(4, 21, 2000000, 16);
    cfg_write(5, 22, 5, 16);
    exp_start(3, 0, 0, 20);
    exp_start(4, 2000000, 0, 21);
    exp_start(5, 1621325, 2000000, 22);
    exp_evt(1);
    start_run(3, 5);
    finish_layer(0);
    finish_layer(0);
    finish_layer(1);

    // invalid ranges are ignored
    @(negedge clk);
    start_CNN = 1; first_layer = 5; last_layer = 3;
    @(negedge clk);
    start_CNN = 0;
    repeat (4) @(negedge clk);
    check("bad_range_busy", busy, 0);
    start_CNN = 1; first_layer = 2; last_layer = 13;
    @(negedge clk);
    start_CNN = 0;
    repeat (4) @(negedge clk);
    check("bad_last_busy", busy, 0);

    // table write while busy is dropped
    exp_start(0, 0, 0, 10);
    exp_evt(1);
    start_run(0, 0);
    cfg_write(0, 99, 7, 16);
    finish_layer(1);
    exp_start(0, 0, 0, 10);
    exp_start(1, 100, 0, 11);
    exp_evt(1);
    start_run(0, 1);
    finish_layer(0);
    finish_layer(1);

    // abort beats a simultaneous done_layer
    exp_start(0, 0, 0, 10);
    exp_evt(2);
    start_run(0, 1);
    repeat (3) @(negedge clk);
    abort = 1; done_layer = 1;
    @(negedge clk);
    abort = 0; done_layer = 0;
    check("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("abort_idle", busy, 0);

    // reset mid-run, then a single-layer run
    exp_start(0, 0, 0, 10);
    exp_start(1, 100, 0, 11);
    start_run(0, 2);
    finish_layer(0);
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_count", count_layer, 0);
    check("midrst_wr", start_write_addr, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    exp_start(0, 0, 0, 10);
    exp_evt(1);
    start_run(0, 0);
    finish_layer(1);

    // start with same-cycle write to first entry
    cfg_write(6, 30, 10, 16);
    exp_start(6, 0, 0, 30);
    exp_evt(1);
    @(negedge clk);
    start_CNN = 1; first_layer = 6; last_layer = 6;
    cfg_we = 1; cfg_addr = 6; cfg_wdata = pack(31, 10, 16);
    @(negedge clk);
    start_CNN = 0; cfg_we = 0;
    wait_start();
    finish_layer(1);
    exp_start(6, 0, 0, 31);
    exp_evt(1);
    start_run(6, 6);
    finish_layer(1);

    repeat (5) @(negedge clk);
    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
